// File: rtl/jtopl_eg_cfg.sv
// rtl/jtopl_eg_cfg.sv - OPL2 envelope register file and slot sequencer feeding jtopl_eg
module jtopl_eg_cfg #(
    parameter int SLOTS = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic       wr,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       zero,
    output logic [4:0] slot_I,
    output logic       en_sus_I,
    output logic [3:0] arate_I,
    output logic [3:0] drate_I,
    output logic [3:0] sl_I,
    output logic [3:0] rrate_I,
    output logic       keyon_I,
    output logic [9:0] fnum_I,
    output logic [2:0] block_I,
    output logic       ksr_II,
    output logic       amsen_IV,
    output logic [5:0] tl_IV,
    output logic [1:0] ksl_IV,
    output logic       ams_IV
);
    logic [7:0] addr_latch;
    logic [4:0] cnt;

    logic       ensus_m [SLOTS];
    logic       ksr_m   [SLOTS];
    logic       amsen_m [SLOTS];
    logic [5:0] tl_m    [SLOTS];
    logic [1:0] ksl_m   [SLOTS];
    logic [3:0] ar_m    [SLOTS];
    logic [3:0] dr_m    [SLOTS];
    logic [3:0] sl_m    [SLOTS];
    logic [3:0] rr_m    [SLOTS];
    logic [9:0] fnum_m  [9];
    logic [2:0] block_m [9];
    logic       keyon_m [9];

    logic       ksr_I;
    logic       am_p1, am_p2, am_p3;
    logic [5:0] tl_p1, tl_p2, tl_p3;
    logic [1:0] ksl_p1, ksl_p2, ksl_p3;

    // Operator offset: two-bit row of six slots plus a 0..5 column
    logic [4:0] off;
    logic       op_ok;
    logic [4:0] op_slot;
    logic       ch_ok;
    logic [3:0] wch;

    always_comb begin
        off     = addr_latch[4:0];
        op_ok   = (off[2:0] < 3'd6) && (off[4:3] != 2'd3);
        op_slot = 5'(off[4:3]) * 5'd6 + 5'(off[2:0]);
        wch     = addr_latch[3:0];
        ch_ok   = (wch < 4'd9);
    end

    // Channel owning the slot being read: g = cnt/6, ch = g*3 + (cnt%6)%3
    logic [1:0] grp;
    logic [2:0] sub;
    logic [2:0] sub3;
    logic [3:0] rch;

    always_comb begin
        grp = 2'd0;
        sub = cnt[2:0];
        if (cnt >= 5'd12) begin
            grp = 2'd2;
            sub = 3'(cnt - 5'd12);
        end else if (cnt >= 5'd6) begin
            grp = 2'd1;
            sub = 3'(cnt - 5'd6);
        end
        sub3 = (sub >= 3'd3) ? (sub - 3'd3) : sub;
        rch  = 4'(grp) * 4'd3 + 4'(sub3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_latch <= 8'd0;
            cnt        <= 5'd0;
            for (int i = 0; i < SLOTS; i++) begin
                ensus_m[i] <= 1'b0;
                ksr_m[i]   <= 1'b0;
                amsen_m[i] <= 1'b0;
                tl_m[i]    <= 6'd0;
                ksl_m[i]   <= 2'd0;
                ar_m[i]    <= 4'd0;
                dr_m[i]    <= 4'd0;
                sl_m[i]    <= 4'd0;
                rr_m[i]    <= 4'd0;
            end
            for (int i = 0; i < 9; i++) begin
                fnum_m[i]  <= 10'd0;
                block_m[i] <= 3'd0;
                keyon_m[i] <= 1'b0;
            end
            zero     <= 1'b0;
            slot_I   <= 5'd0;
            en_sus_I <= 1'b0;
            arate_I  <= 4'd0;
            drate_I  <= 4'd0;
            sl_I     <= 4'd0;
            rrate_I  <= 4'd0;
            keyon_I  <= 1'b0;
            fnum_I   <= 10'd0;
            block_I  <= 3'd0;
            ksr_I    <= 1'b0;
            ksr_II   <= 1'b0;
            am_p1    <= 1'b0;
            am_p2    <= 1'b0;
            am_p3    <= 1'b0;
            amsen_IV <= 1'b0;
            tl_p1    <= 6'd0;
            tl_p2    <= 6'd0;
            tl_p3    <= 6'd0;
            tl_IV    <= 6'd0;
            ksl_p1   <= 2'd0;
            ksl_p2   <= 2'd0;
            ksl_p3   <= 2'd0;
            ksl_IV   <= 2'd0;
            ams_IV   <= 1'b0;
        end else begin
            if (wr && !a0) begin
                addr_latch <= din;
            end else if (wr && a0) begin
                case (addr_latch[7:5])
                    3'd1: if (op_ok) begin
                        amsen_m[op_slot] <= din[7];
                        ensus_m[op_slot] <= din[5];
                        ksr_m[op_slot]   <= din[4];
                    end
                    3'd2: if (op_ok) begin
                        ksl_m[op_slot] <= din[7:6];
                        tl_m[op_slot]  <= din[5:0];
                    end
                    3'd3: if (op_ok) begin
                        ar_m[op_slot] <= din[7:4];
                        dr_m[op_slot] <= din[3:0];
                    end
                    3'd4: if (op_ok) begin
                        sl_m[op_slot] <= din[7:4];
                        rr_m[op_slot] <= din[3:0];
                    end
                    3'd5: begin
                        if (addr_latch[4] == 1'b0 && ch_ok) begin
                            fnum_m[wch][7:0] <= din;
                        end else if (addr_latch[4] && ch_ok) begin
                            keyon_m[wch]     <= din[5];
                            block_m[wch]     <= din[4:2];
                            fnum_m[wch][9:8] <= din[1:0];
                        end else if (addr_latch == 8'hBD) begin
                            ams_IV <= din[7];
                        end
                    end
                    default: ;
                endcase
            end

            // Array reads here see pre-write contents, so a colliding write lands next frame
            if (cenop) begin
                cnt      <= (cnt == 5'(SLOTS - 1)) ? 5'd0 : cnt + 5'd1;
                zero     <= (cnt == 5'd0);
                slot_I   <= cnt;
                en_sus_I <= ensus_m[cnt];
                arate_I  <= ar_m[cnt];
                drate_I  <= dr_m[cnt];
                sl_I     <= sl_m[cnt];
                rrate_I  <= rr_m[cnt];
                keyon_I  <= keyon_m[rch];
                fnum_I   <= fnum_m[rch];
                block_I  <= block_m[rch];
                ksr_I    <= ksr_m[cnt];
                ksr_II   <= ksr_I;
                am_p1    <= amsen_m[cnt];
                am_p2    <= am_p1;
                am_p3    <= am_p2;
                amsen_IV <= am_p3;
                tl_p1    <= tl_m[cnt];
                tl_p2    <= tl_p1;
                tl_p3    <= tl_p2;
                tl_IV    <= tl_p3;
                ksl_p1   <= ksl_m[cnt];
                ksl_p2   <= ksl_p1;
                ksl_p3   <= ksl_p2;
                ksl_IV   <= ksl_p3;
            end
        end
    end
endmodule

// File: tb/tb_jtopl_eg_cfg.sv
// tb/tb_jtopl_eg_cfg.sv - scoreboard bench for jtopl_eg_cfg
module tb_jtopl_eg_cfg;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cenop = 1'b0;
    logic       wr = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'd0;
    logic       zero;
    logic [4:0] slot_I;
    logic       en_sus_I;
    logic [3:0] arate_I, drate_I, sl_I, rrate_I;
    logic       keyon_I;
    logic [9:0] fnum_I;
    logic [2:0] block_I;
    logic       ksr_II, amsen_IV;
    logic [5:0] tl_IV;
    logic [1:0] ksl_IV;
    logic       ams_IV;

    jtopl_eg_cfg dut (
        .clk(clk), .rst(rst), .cenop(cenop), .wr(wr), .a0(a0), .din(din),
        .zero(zero), .slot_I(slot_I), .en_sus_I(en_sus_I), .arate_I(arate_I),
        .drate_I(drate_I), .sl_I(sl_I), .rrate_I(rrate_I), .keyon_I(keyon_I),
        .fnum_I(fnum_I), .block_I(block_I), .ksr_II(ksr_II), .amsen_IV(amsen_IV),
        .tl_IV(tl_IV), .ksl_IV(ksl_IV), .ams_IV(ams_IV)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       zero;
        logic [4:0] slot;
        logic       en_sus;
        logic [3:0] ar, dr, sl, rr;
        logic       keyon;
        logic [9:0] fnum;
        logic [2:0] block;
        logic       ksr;
        logic       amsen;
        logic [5:0] tl;
        logic [1:0] ksl;
        logic       ams;
    } vec_t;

    vec_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_seen = 0;

    // Hand-derived slot -> channel table
    int ch_of [18] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 6, 7, 8};

    logic       m_ensus [18], m_ksr [18], m_amsen [18];
    logic [5:0] m_tl [18];
    logic [1:0] m_ksl [18];
    logic [3:0] m_ar [18], m_dr [18], m_sl [18], m_rr [18];
    logic [9:0] m_fnum [9];
    logic [2:0] m_block [9];
    logic       m_keyon [9];
    logic       m_ams;
    logic       h_ksr [3], h_am [3];
    logic [5:0] h_tl [3];
    logic [1:0] h_ksl [3];
    int         cnt;

    task automatic clear_model();
        for (int i = 0; i < 18; i++) begin
            m_ensus[i] = 0; m_ksr[i] = 0; m_amsen[i] = 0; m_tl[i] = 0; m_ksl[i] = 0;
            m_ar[i] = 0; m_dr[i] = 0; m_sl[i] = 0; m_rr[i] = 0;
        end
        for (int i = 0; i < 9; i++) begin
            m_fnum[i] = 0; m_block[i] = 0; m_keyon[i] = 0;
        end
        for (int i = 0; i < 3; i++) begin
            h_ksr[i] = 0; h_am[i] = 0; h_tl[i] = 0; h_ksl[i] = 0;
        end
        m_ams = 0;
        cnt = 0;
    endtask

    task automatic push_exp();
        vec_t e;
        int   ch;
        ch       = ch_of[cnt];
        e.zero   = (cnt == 0);
        e.slot   = 5'(cnt);
        e.en_sus = m_ensus[cnt];
        e.ar     = m_ar[cnt];
        e.dr     = m_dr[cnt];
        e.sl     = m_sl[cnt];
        e.rr     = m_rr[cnt];
        e.keyon  = m_keyon[ch];
        e.fnum   = m_fnum[ch];
        e.block  = m_block[ch];
        e.ksr    = h_ksr[0];
        e.amsen  = h_am[2];
        e.tl     = h_tl[2];
        e.ksl    = h_ksl[2];
        e.ams    = m_ams;
        q.push_back(e);
        for (int i = 2; i > 0; i--) begin
            h_ksr[i] = h_ksr[i-1]; h_am[i] = h_am[i-1];
            h_tl[i] = h_tl[i-1]; h_ksl[i] = h_ksl[i-1];
        end
        h_ksr[0] = m_ksr[cnt]; h_am[0] = m_amsen[cnt];
        h_tl[0] = m_tl[cnt]; h_ksl[0] = m_ksl[cnt];
        cnt = (cnt == 17) ? 0 : cnt + 1;
    endtask

    task automatic cen();
        push_exp();
        @(negedge clk) cenop = 1'b1;
        @(negedge clk) cenop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame();
        repeat (18) cen();
    endtask

    task automatic wa(input logic [7:0] a);
        @(negedge clk) begin wr = 1'b1; a0 = 1'b0; din = a; end
        @(negedge clk) wr = 1'b0;
    endtask

    task automatic wd(input logic [7:0] d);
        @(negedge clk) begin wr = 1'b1; a0 = 1'b1; din = d; end
        @(negedge clk) wr = 1'b0;
    endtask

    task automatic wreg(input logic [7:0] a, input logic [7:0] d);
        wa(a);
        wd(d);
    endtask

    task automatic push_zero();
        vec_t e;
        e = '0;
        q.push_back(e);
    endtask

    initial begin : monitor
        vec_t act, e;
        forever begin
            @(posedge clk);
            if (cenop || rst) begin
                #1;
                act = {zero, slot_I, en_sus_I, arate_I, drate_I, sl_I, rrate_I, keyon_I,
                       fnum_I, block_I, ksr_II, amsen_IV, tl_IV, ksl_IV, ams_IV};
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_output #%0d got %h required none", n_seen, act);
                end else begin
                    e = q.pop_front();
                    if (act !== e)
                        $display("FAIL out_%0d got %h required %h", n_seen, act, e);
                    else
                        n_pass++;
                end
                n_seen++;
            end
        end
    end

    initial begin
        int guard;
        clear_model();
        push_zero();
        push_zero();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        repeat (19) cen();

        wreg(8'h63, 8'hA5);
        m_ar[3] = 4'hA; m_dr[3] = 4'h5;
        frame();

        wreg(8'h4B, 8'hC7);
        m_tl[9] = 6'd7; m_ksl[9] = 2'd3;
        wreg(8'h2B, 8'h10);
        m_ksr[9] = 1'b1;
        wreg(8'h20, 8'hA0);
        m_amsen[0] = 1'b1; m_ensus[0] = 1'b1;
        wreg(8'hBD, 8'h80);
        m_ams = 1'b1;
        frame();

        wreg(8'hA4, 8'h34);
        wreg(8'hB4, 8'h2D);
        m_fnum[4] = 10'h134; m_block[4] = 3'd3; m_keyon[4] = 1'b1;
        wreg(8'h84, 8'h5A);
        m_sl[4] = 4'h5; m_rr[4] = 4'hA;
        frame();

        wreg(8'h26, 8'hFF);
        wreg(8'hA9, 8'hFF);
        wreg(8'h36, 8'hFF);
        wreg(8'h58, 8'hFF);
        wreg(8'hC0, 8'hFF);
        wa(8'h45);
        wd(8'h81);
        wd(8'h82);
        m_tl[5] = 6'd2; m_ksl[5] = 2'd2;
        frame();

        while (cnt != 5) cen();
        wa(8'h65);
        push_exp();
        @(negedge clk) begin cenop = 1'b1; wr = 1'b1; a0 = 1'b1; din = 8'h9C; end
        @(negedge clk) begin cenop = 1'b0; wr = 1'b0; end
        repeat (2) @(negedge clk);
        m_ar[5] = 4'h9; m_dr[5] = 4'hC;
        frame();

        while (cnt != 11) cen();
        push_zero();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        clear_model();
        repeat (19) cen();

        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain got %0d pending required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jtopl_eg_cfg.md
Name: jtopl_eg_cfg

Overview:
- Host-side register file and slot sequencer that feeds the envelope generator (jtopl_eg) its per-slot configuration in pipeline order.
- Accepts OPL-style address/data writes and stores operator and channel envelope fields for 18 slots (9 channels x 2 operators).
- Replays the stored fields time-multiplexed at operator rate, aligned to the EG's stages I, II and IV.
- Produces the `zero` frame marker consumed by jtopl_eg.

Parameters:
- SLOTS, 18, number of operator slots per frame (fixed for OPL2 mode; other values unsupported).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cenop  input  1  operator-rate clock enable (from jtopl_div)
- wr  input  1  host write strobe, one clk per access
- a0  input  1  0 = address write, 1 = data write
- din  input  8  host write data
- zero  output  1  high for the cenop period in which slot 0 stage-I data is presented
- slot_I  output  5  slot index of stage-I outputs, 0..17
- en_sus_I  output  1  reg 0x20+ bit5 (EGT)
- arate_I  output  4  reg 0x60+ bits7:4
- drate_I  output  4  reg 0x60+ bits3:0
- sl_I  output  4  reg 0x80+ bits7:4
- rrate_I  output  4  reg 0x80+ bits3:0
- keyon_I  output  1  channel reg 0xB0+ bit5
- fnum_I  output  10  {0xB0+ bits1:0, 0xA0+ bits7:0}
- block_I  output  3  0xB0+ bits4:2
- ksr_II  output  1  reg 0x20+ bit4, one cenop after stage I
- amsen_IV  output  1  reg 0x20+ bit7, three cenops after stage I
- tl_IV  output  6  reg 0x40+ bits5:0, three cenops after stage I
- ksl_IV  output  2  reg 0x40+ bits7:6, three cenops after stage I
- ams_IV  output  1  global reg 0xBD bit7, registered

Behaviour:
- Reset:
  - All stored fields, the latched address and every output clear to 0.
  - Slot counter cnt clears to 0.
  - Reset mid-frame aborts the frame; the first cenop after reset presents slot 0.
- Address phase:
  - wr & !a0: addr_latch <= din.
  - Address writes never modify configuration.
- Data phase: wr & a0 decodes addr_latch.
  - Operator groups: 0x20-0x35, 0x40-0x55, 0x60-0x75, 0x80-0x95.
    - off = addr[4:0]; off[2:0] of 6 or 7 is invalid and the write is ignored.
    - Otherwise slot = off[4:3]*6 + off[2:0]. Offsets 0x16-0x1F are ignored.
  - Channel groups: 0xA0-0xA8 and 0xB0-0xB8 select ch = addr[3:0]. ch > 8 is ignored.
  - 0xBD updates ams.
  - All other addresses are ignored. Repeated data writes reuse the latched address.
- Slot-to-channel map: g = slot/6, sub = slot%6, ch = g*3 + sub%3. sub >= 3 is the carrier (op 1).
- Sequencing: on each clk with cenop=1:
  - cnt <= (cnt==17) ? 0 : cnt+1.
  - Stage-I outputs load cfg[cnt], with channel fields taken from ch(cnt).
  - slot_I <= cnt; zero <= (cnt==0).
- Pipelining:
  - The stage-II register takes the stage-I ksr of the previous cenop.
  - Stage-IV registers take a 3-deep cenop-gated pipe of amsen/tl/ksl.
  - With cenop low, all outputs hold.
- Write/read collision: a write on the same clk as a cenop read of the same slot or channel delivers the old value. The new value appears at that slot's next frame.
- Keyon is per channel, so both operators of a channel see the same keyon_I.
- Wrap-around: slot 17 is followed by slot 0 with zero=1. The period is exactly 18 cenops.

Test Plan:
- Reset, then 19 cenops:
  - zero high only on the 1st and 19th cenop.
  - slot_I sequence is 0,1..17,0.
  - All config outputs 0.
- Write 0x63 -> 0xA5:
  - Slot 3 presents arate_I=0xA and drate_I=0x5.
  - All other slots remain 0.
- Write 0x4B -> 0xC7 (slot 9):
  - tl_IV=7 and ksl_IV=3 appear exactly three cenops after slot_I=9.
  - Write 0x2B -> 0x10: ksr_II=1 one cenop after slot_I=9.
- Write 0xA4 -> 0x34 and 0xB4 -> 0x2D (ch 4):
  - Slots 7 and 10 show keyon_I=1, block_I=3, fnum_I=0x134.
- Write to 0x26 and 0xA9 -> 0xFF: no output change in any slot.
- Data write landing on the same clk as slot 5's cenop read:
  - That frame shows the old value.
  - The next frame shows the new value.
- Assert rst at slot 11: the next outputs are zero and slot 0 with zero=1.
